data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the pipelined CPU's data port (d_readM/d_writeM/d_address/d_data) and the slow line-wide data memory.
- Drives one bit of the CPU's 2-bit cacheStall bus: bit 1 = data cache, bit 0 = instruction cache.
- Read hits complete in the request cycle. Read misses fill a whole line. Writes are forwarded word-wise to memory; the CPU stalls until each write is acknowledged.

---
 rtl/data_cache_pkg.sv | 58 +++++
 rtl/data_cache_array.sv | 67 ++++++
 rtl/data_cache.sv | 179 +++++++++++++++++
 tb/tb_data_cache.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// -----------------------------------------------------------------------------
// data_cache_pkg
// Shared definitions for the direct-mapped, write-through data cache:
//   - default geometry (WORD_SIZE, NUM_LINES, WORDS_PER_LINE) and the address
//     field widths derived from it (OFFSET_BITS, INDEX_BITS, TAG_BITS)
//   - controller state encoding
//   - address-field extraction helpers. The field widths are arguments, so a
//     cache built with non-default geometry can use the same helpers.
// -----------------------------------------------------------------------------
package data_cache_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int NUM_LINES      = 4;
    localparam int WORDS_PER_LINE = 4;

    localparam int OFFSET_BITS = $clog2(WORDS_PER_LINE);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS    = WORD_SIZE - OFFSET_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } state_t;

    // Low 'bits' bits of a word, all ones.
    function automatic logic [WORD_SIZE-1:0] low_mask(input int bits);
        return (WORD_SIZE'(1) << bits) - WORD_SIZE'(1);
    endfunction

    // Word offset inside the line (right-aligned).
    function automatic logic [WORD_SIZE-1:0] addr_offset(input logic [WORD_SIZE-1:0] addr,
                                                         input int off_bits);
        return addr & low_mask(off_bits);
    endfunction

    // Line index (right-aligned).
    function automatic logic [WORD_SIZE-1:0] addr_index(input logic [WORD_SIZE-1:0] addr,
                                                        input int off_bits,
                                                        input int idx_bits);
        return (addr >> off_bits) & low_mask(idx_bits);
    endfunction

    // Tag: everything above offset and index (right-aligned).
    function automatic logic [WORD_SIZE-1:0] addr_tag(input logic [WORD_SIZE-1:0] addr,
                                                      input int off_bits,
                                                      input int idx_bits);
        return addr >> (off_bits + idx_bits);
    endfunction

    // Address of the first word of the line containing addr.
    function automatic logic [WORD_SIZE-1:0] line_address(input logic [WORD_SIZE-1:0] addr,
                                                          input int off_bits);
        return addr & ~low_mask(off_bits);
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// -----------------------------------------------------------------------------
// cache_tag_data_array
// Valid / tag / data storage for a direct-mapped cache.
// Ports:
//   Clk, Reset                 clock; synchronous active-high reset clears
//                              all valid bits (tags and data are left as is)
//   rd_index -> rd_valid,      combinational read port returning the valid
//   rd_tag, rd_line            bit, tag and whole line of one index
//   fill_en/index/tag/line     full-line fill; sets the valid bit
//   upd_en/index/offset/data   single-word update of a resident line
// -----------------------------------------------------------------------------
module cache_tag_data_array
    import data_cache_pkg::*;
#(
    parameter int WORD_SIZE      = 16,
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                        Clk,
    input  logic                                        Reset,
    input  logic [$clog2(NUM_LINES)-1:0]                rd_index,
    output logic                                        rd_valid,
    output logic [WORD_SIZE-$clog2(WORDS_PER_LINE)-$clog2(NUM_LINES)-1:0] rd_tag,
    output logic [WORD_SIZE*WORDS_PER_LINE-1:0]         rd_line,
    input  logic                                        fill_en,
    input  logic [$clog2(NUM_LINES)-1:0]                fill_index,
    input  logic [WORD_SIZE-$clog2(WORDS_PER_LINE)-$clog2(NUM_LINES)-1:0] fill_tag,
    input  logic [WORD_SIZE*WORDS_PER_LINE-1:0]         fill_line,
    input  logic                                        upd_en,
    input  logic [$clog2(NUM_LINES)-1:0]                upd_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]           upd_offset,
    input  logic [WORD_SIZE-1:0]                        upd_data
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
    localparam int LINE_W = WORD_SIZE * WORDS_PER_LINE;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [LINE_W-1:0]    lines [NUM_LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = lines[rd_index];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_index] <= 1'b1;
        end
    end

    // Tags and data carry no reset: a line is meaningless until its valid bit
    // is set by a fill, which writes tag and data in the same cycle.
    always_ff @(posedge Clk) begin
        if (fill_en) begin
            tags[fill_index]  <= fill_tag;
            lines[fill_index] <= fill_line;
        end else if (upd_en) begin
            lines[upd_index][upd_offset*WORD_SIZE +: WORD_SIZE] <= upd_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// data port and a line-wide data memory.
// Ports:
//   Clk, Reset          clock; synchronous active-high reset
//   cpu_read/cpu_write  CPU request (write wins when both are set)
//   cpu_address         word address, cpu_wdata write data
//   cpu_rdata           read data, valid for a read while cache_stall is 0
//   cache_stall         combinational pipeline hold
//   mem_read/mem_write  memory request, held until mem_ack
//   mem_address         line address for reads, word address for writes
//   mem_wdata           write data to memory
//   mem_rline, mem_ack  returned line (word 0 in LSBs) and completion pulse
//   hit_count/miss_count  saturating read hit / miss counters
// -----------------------------------------------------------------------------
module data_cache
#(
    parameter int WORD_SIZE      = 16,
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                cpu_read,
    input  logic                                cpu_write,
    input  logic [WORD_SIZE-1:0]                cpu_address,
    input  logic [WORD_SIZE-1:0]                cpu_wdata,
    output logic [WORD_SIZE-1:0]                cpu_rdata,
    output logic                                cache_stall,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [WORD_SIZE-1:0]                mem_address,
    output logic [WORD_SIZE-1:0]                mem_wdata,
    input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_rline,
    input  logic                                mem_ack,
    output logic [15:0]                         hit_count,
    output logic [15:0]                         miss_count
);
    import data_cache_pkg::*;

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
    localparam int LINE_W = WORD_SIZE * WORDS_PER_LINE;

    state_t state, next_state;

    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;

    logic [OFF_W-1:0]  req_offset, lat_offset;
    logic [IDX_W-1:0]  req_index, lat_index, rd_index;
    logic [TAG_W-1:0]  req_tag, lat_tag, rd_tag;
    logic              rd_valid;
    logic [LINE_W-1:0] rd_line;
    logic              req_hit, lat_hit;
    logic              latch_en, fill_en, upd_en, hit_inc, miss_inc;

    assign req_offset = OFF_W'(addr_offset(cpu_address, OFF_W));
    assign req_index  = IDX_W'(addr_index(cpu_address, OFF_W, IDX_W));
    assign req_tag    = TAG_W'(addr_tag(cpu_address, OFF_W, IDX_W));
    assign lat_offset = OFF_W'(addr_offset(addr_q, OFF_W));
    assign lat_index  = IDX_W'(addr_index(addr_q, OFF_W, IDX_W));
    assign lat_tag    = TAG_W'(addr_tag(addr_q, OFF_W, IDX_W));

    // The single read port looks up the live CPU address while idle and the
    // latched request address otherwise (write-hit check on ack).
    assign rd_index = (state == IDLE) ? req_index : lat_index;
    assign req_hit  = rd_valid && (rd_tag == req_tag);
    assign lat_hit  = rd_valid && (rd_tag == lat_tag);

    cache_tag_data_array #(
        .WORD_SIZE      (WORD_SIZE),
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .Clk        (Clk),
        .Reset      (Reset),
        .rd_index   (rd_index),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .fill_en    (fill_en),
        .fill_index (lat_index),
        .fill_tag   (lat_tag),
        .fill_line  (mem_rline),
        .upd_en     (upd_en),
        .upd_index  (lat_index),
        .upd_offset (lat_offset),
        .upd_data   (wdata_q)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            state <= next_state;
            if (hit_inc && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss_inc && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (latch_en) begin
            addr_q  <= cpu_address;
            wdata_q <= cpu_wdata;
        end
    end

    always_comb begin
        next_state  = state;
        cache_stall = 1'b0;
        cpu_rdata   = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        latch_en    = 1'b0;
        fill_en     = 1'b0;
        upd_en      = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_write) begin
                    cache_stall = 1'b1;
                    latch_en    = 1'b1;
                    next_state  = WRITE;
                end else if (cpu_read) begin
                    if (req_hit) begin
                        cpu_rdata = rd_line[req_offset*WORD_SIZE +: WORD_SIZE];
                        hit_inc   = 1'b1;
                    end else begin
                        cache_stall = 1'b1;
                        latch_en    = 1'b1;
                        miss_inc    = 1'b1;
                        next_state  = FILL;
                    end
                end
            end
            FILL: begin
                cache_stall = 1'b1;
                mem_read    = 1'b1;
                mem_address = line_address(addr_q, OFF_W);
                if (mem_ack) begin
                    fill_en    = 1'b1;
                    next_state = IDLE;
                end
            end
            WRITE: begin
                cache_stall = 1'b1;
                mem_write   = 1'b1;
                mem_address = addr_q;
                mem_wdata   = wdata_q;
                if (mem_ack) begin
                    // Write-through: refresh the cached copy only if resident.
                    upd_en     = lat_hit;
                    next_state = WDONE;
                end
            end
            WDONE: begin
                // One unstalled cycle lets the CPU retire the write; returning
                // to IDLE afterwards keeps the same write from being reissued.
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_address, cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cache_stall;
    logic        mem_read, mem_write;
    logic [15:0] mem_address, mem_wdata;
    logic [63:0] mem_rline;
    logic        mem_ack;
    logic [15:0] hit_count, miss_count;

    data_cache dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cache_stall (cache_stall),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rline   (mem_rline),
        .mem_ack     (mem_ack),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } xact_t;

    xact_t rq[$];            // expected read completions
    xact_t wq[$];            // expected memory writes

    logic [15:0] mem     [65536];   // memory behind the DUT
    logic [15:0] ref_mem [65536];   // what the CPU should observe

    // Reference cache view: which line address is resident at each index.
    bit          m_valid [4];
    int          m_line  [4];
    int          exp_hits, exp_miss;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat_fixed = 0;
    int          last_lat  = 0;
    bit          stray     = 1'b0;
    logic [15:0] cur_addr  = 16'h0;

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory: acknowledges each request after a (random or fixed) number of
    // request cycles; can also emit an unsolicited ack pulse.
    initial begin
        int cnt, target;
        cnt = 0; target = 1;
        mem_ack = 1'b0;
        mem_rline = '0;
        forever begin
            @(posedge Clk); #1;
            mem_ack = 1'b0;
            if (stray) begin
                mem_ack = 1'b1;
                stray   = 1'b0;
            end else if (mem_read || mem_write) begin
                if (cnt == 0) target = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
                cnt++;
                if (cnt == target) begin
                    mem_ack  = 1'b1;
                    last_lat = target;
                    cnt      = 0;
                    if (mem_write) mem[mem_address] = mem_wdata;
                    else for (int w = 0; w < 4; w++) mem_rline[w*16 +: 16] = mem[int'(mem_address) + w];
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        xact_t e;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (cpu_read && !cpu_write && !cache_stall) begin
                    if (rq.size() == 0) check("unexpected_read", cpu_rdata, 16'hxxxx);
                    else begin
                        e = rq.pop_front();
                        check("read_data", cpu_rdata, e.data);
                    end
                end else if (cpu_read) begin
                    check("rdata_zero_when_stalled", cpu_rdata, 16'h0);
                end
                if (mem_read || mem_write)
                    check("mem_rd_wr_exclusive", {15'b0, mem_read & mem_write}, 16'h0);
                if (mem_ack && mem_read)
                    check("fill_address", mem_address, cur_addr & 16'hFFFC);
                if (mem_ack && mem_write) begin
                    if (wq.size() == 0) check("unexpected_write", mem_address, 16'hxxxx);
                    else begin
                        e = wq.pop_front();
                        check("write_address", mem_address, e.addr);
                        check("write_data", mem_wdata, e.data);
                    end
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        rq.delete();
        wq.delete();
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_hit_count"},  hit_count,  16'(exp_hits));
        check({tag, "_miss_count"}, miss_count, 16'(exp_miss));
    endtask

    // One CPU access, held until the cache releases the stall.
    task automatic issue(input bit is_wr, input logic [15:0] a, input logic [15:0] d);
        int  line, idx, stalls, guard, exp_st;
        bit  hit;
        line = int'(a) / 4;
        idx  = line % 4;
        hit  = 1'b0;
        if (is_wr) begin
            wq.push_back('{addr: a, data: d});
            ref_mem[a] = d;
        end else begin
            hit = m_valid[idx] && (m_line[idx] == line);
            if (!hit) begin
                m_valid[idx] = 1'b1;
                m_line[idx]  = line;
                exp_miss++;
            end
            exp_hits++;
            rq.push_back('{addr: a, data: ref_mem[a]});
        end
        cur_addr    = a;
        cpu_read    = !is_wr;
        cpu_write   = is_wr;
        cpu_address = a;
        cpu_wdata   = d;
        stalls = 0;
        guard  = 0;
        do begin
            @(negedge Clk);
            if (cache_stall) stalls++;
            guard++;
        end while (cache_stall && guard < 64);
        if (guard >= 64) check("timeout_stall", {15'b0, cache_stall}, 16'h0);
        exp_st = (is_wr || !hit) ? last_lat + 1 : 0;
        check(is_wr ? "write_stall_cycles" : "read_stall_cycles", 16'(stalls), 16'(exp_st));
        @(posedge Clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v, a;
        int guard;
        for (int i = 0; i < 65536; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[16'h10] = 16'hA; mem[16'h11] = 16'hB; mem[16'h12] = 16'hC; mem[16'h13] = 16'hD;
        ref_mem[16'h10] = 16'hA; ref_mem[16'h11] = 16'hB;
        ref_mem[16'h12] = 16'hC; ref_mem[16'h13] = 16'hD;

        Reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_address = '0; cpu_wdata = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("reset_stall", {15'b0, cache_stall}, 16'h0);
        check("reset_mem_read", {15'b0, mem_read}, 16'h0);
        check("reset_mem_write", {15'b0, mem_write}, 16'h0);
        check("reset_rdata", cpu_rdata, 16'h0);
        check_cnt("reset");
        @(posedge Clk); #1;

        // Cold read: 3-cycle memory latency
        lat_fixed = 3;
        issue(1'b0, 16'h0012, 16'h0);
        check_cnt("cold_read");
        // Same-line hits back to back
        issue(1'b0, 16'h0010, 16'h0);
        issue(1'b0, 16'h0013, 16'h0);
        check_cnt("same_line");
        // Write-through hit
        lat_fixed = 2;
        issue(1'b1, 16'h0011, 16'h55AA);
        issue(1'b0, 16'h0011, 16'h0);
        check_cnt("write_hit");
        // Write miss, no allocate
        issue(1'b1, 16'h0F20, 16'h1234);
        issue(1'b0, 16'h0F20, 16'h0);
        check_cnt("write_miss");
        // Conflict eviction on index 0
        lat_fixed = 0;
        issue(1'b0, 16'h0012, 16'h0);
        issue(1'b0, 16'h0052, 16'h0);
        issue(1'b0, 16'h0012, 16'h0);
        check_cnt("conflict");

        // Reset in the middle of a fill, then a stray ack
        lat_fixed   = 20;
        cur_addr    = 16'h0F30;
        cpu_read    = 1'b1;
        cpu_address = 16'h0F30;
        guard = 0;
        do begin
            @(negedge Clk);
            guard++;
        end while (!mem_read && guard < 16);
        check("midfill_mem_read_seen", {15'b0, mem_read}, 16'h1);
        @(posedge Clk); #1;
        Reset = 1'b1; cpu_read = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        model_reset();
        lat_fixed = 0;
        @(negedge Clk);
        check("after_reset_mem_read", {15'b0, mem_read}, 16'h0);
        check("after_reset_stall", {15'b0, cache_stall}, 16'h0);
        check_cnt("after_reset");
        @(posedge Clk); #1;
        stray = 1'b1;
        repeat (3) @(negedge Clk);
        check("stray_ack_mem_read", {15'b0, mem_read}, 16'h0);
        check("stray_ack_mem_write", {15'b0, mem_write}, 16'h0);
        check("stray_ack_stall", {15'b0, cache_stall}, 16'h0);
        @(posedge Clk); #1;
        issue(1'b0, 16'h0012, 16'h0);
        check_cnt("read_after_reset");

        // Random traffic over four tags so lines conflict often
        for (int n = 0; n < 400; n++) begin
            a = 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            if ($urandom_range(0, 9) < 3) issue(1'b1, a, 16'($urandom));
            else                          issue(1'b0, a, 16'h0);
        end
        @(negedge Clk);
        check_cnt("final");
        check("read_queue_drained", 16'(rq.size()), 16'h0);
        check("write_queue_drained", 16'(wq.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
